// File: rtl/sum_bcd_display_driver_pkg.sv
// Shared definitions for the sum display driver.
//   state_t      : converter FSM encoding (IDLE, SHIFT, DONE)
//   DSEL_ONES    : digit enable for the ones digit
//   DSEL_TENS    : digit enable for the tens digit
//   SEG_BLANK    : active-high "all segments off" code
//   SEG_TABLE    : active-high {a,b,c,d,e,f,g} codes for digits 0..9, index = digit
package sum_bcd_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] DSEL_ONES = 2'b01;
  localparam logic [1:0] DSEL_TENS = 2'b10;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry 0 sits in the least significant slot so SEG_TABLE[d] is digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h7B, 7'h7F, 7'h70, 7'h5F, 7'h5B,
    7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
  };

endpackage

// File: rtl/sum_bcd_display_driver_bcd_to_seg7.sv
// Combinational BCD to 7-segment decoder (active-high segments).
//   bcd   in  4  BCD digit; codes 10..15 decode to blank
//   blank in  1  force all segments off
//   seg   out 7  {a,b,c,d,e,f,g}
module bcd_to_seg7
  import sum_bcd_display_driver_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    seg = SEG_TABLE[0];
        4'd1:    seg = SEG_TABLE[1];
        4'd2:    seg = SEG_TABLE[2];
        4'd3:    seg = SEG_TABLE[3];
        4'd4:    seg = SEG_TABLE[4];
        4'd5:    seg = SEG_TABLE[5];
        4'd6:    seg = SEG_TABLE[6];
        4'd7:    seg = SEG_TABLE[7];
        4'd8:    seg = SEG_TABLE[8];
        4'd9:    seg = SEG_TABLE[9];
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/sum_bcd_display_driver.sv
// Binary sum to two-digit multiplexed 7-segment display.
// A sequential double-dabble converter produces tens/ones BCD from Din on a Ld
// strobe; a free-running scanner alternates one segment bus between the two
// digit enables, blanking a leading zero on the tens digit.
//   CLK   in   1      clock, rising edge
//   RST   in   1      synchronous reset, active low
//   Din   in   SUM_W  binary value, captured on the accepting Ld edge
//   Ld    in   1      start conversion (ignored while Busy)
//   Busy  out  1      conversion in progress
//   Valid out  1      one-cycle pulse when Tens/Ones update
//   Tens  out  4      BCD tens digit
//   Ones  out  4      BCD ones digit
//   Seg   out  7      {a,b,c,d,e,f,g}, polarity set by SEG_POL
//   Dsel  out  2      one-hot digit enable (01 ones, 10 tens)
module sum_bcd_display_driver
  import sum_bcd_display_driver_pkg::*;
#(
  parameter int SUM_W    = 5,
  parameter int SCAN_DIV = 1000,
  parameter bit SEG_POL  = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [SUM_W-1:0] Din,
  input  logic             Ld,
  output logic             Busy,
  output logic             Valid,
  output logic [3:0]       Tens,
  output logic [3:0]       Ones,
  output logic [6:0]       Seg,
  output logic [1:0]       Dsel
);

  localparam int CNT_W  = $clog2(SUM_W + 1);
  localparam int SCAN_W = $clog2(SCAN_DIV);

  state_t            state_reg;
  logic [SUM_W-1:0]  bin_reg;
  logic [7:0]        bcd_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              busy_reg;
  logic              valid_reg;
  logic [3:0]        tens_reg;
  logic [3:0]        ones_reg;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic [1:0]        dsel_reg;

  // Double-dabble: add 3 to any nibble >= 5 before the shift so it carries
  // correctly into the next decimal digit.
  logic [7:0]        bcd_adj;
  logic [SUM_W+7:0]  shift_next;
  genvar gi;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 :
                                  bcd_reg[gi*4 +: 4];
    end
  endgenerate

  assign shift_next = {bcd_adj, bin_reg} << 1;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      tens_reg  <= '0;
      ones_reg  <= '0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (Ld) begin
            bin_reg   <= Din;
            bcd_reg   <= '0;
            cnt_reg   <= CNT_W'(SUM_W);
            busy_reg  <= 1'b1;
            state_reg <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_reg, bin_reg} <= shift_next;
          cnt_reg <= cnt_reg - CNT_W'(1);
          if (cnt_reg == CNT_W'(1)) begin
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          tens_reg  <= bcd_reg[7:4];
          ones_reg  <= bcd_reg[3:0];
          valid_reg <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Scanner: each digit stays lit for SCAN_DIV cycles; swapping the two bits
  // keeps the enable one-hot by construction.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      scan_cnt_reg <= '0;
      dsel_reg     <= DSEL_ONES;
    end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      dsel_reg     <= {dsel_reg[0], dsel_reg[1]};
    end else begin
      scan_cnt_reg <= scan_cnt_reg + SCAN_W'(1);
    end
  end

  logic       show_tens;
  logic [3:0] digit;
  logic       blank;
  logic [6:0] seg_raw;

  assign show_tens = (dsel_reg == DSEL_TENS);
  assign digit     = show_tens ? tens_reg : ones_reg;
  assign blank     = show_tens && (tens_reg == 4'd0);

  bcd_to_seg7 u_bcd_to_seg7 (
    .bcd   (digit),
    .blank (blank),
    .seg   (seg_raw)
  );

  generate
    if (SEG_POL) begin : g_seg_high
      assign Seg = seg_raw;
    end else begin : g_seg_low
      assign Seg = ~seg_raw;
    end
  endgenerate

  assign Busy  = busy_reg;
  assign Valid = valid_reg;
  assign Tens  = tens_reg;
  assign Ones  = ones_reg;
  assign Dsel  = dsel_reg;

endmodule

// File: tb/tb_sum_bcd_display_driver.sv
module tb_sum_bcd_display_driver;

  localparam int SUM_W = 5;
  localparam int SD    = 8;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             ld    = 1'b0;
  logic [SUM_W-1:0] din   = '0;

  logic       p_busy, p_valid, n_busy, n_valid;
  logic [3:0] p_tens, p_ones, n_tens, n_ones;
  logic [6:0] p_seg, n_seg;
  logic [1:0] p_dsel, n_dsel;

  always #5 clk = ~clk;

  sum_bcd_display_driver #(.SUM_W(SUM_W), .SCAN_DIV(SD), .SEG_POL(1'b1)) dut (
    .CLK(clk), .RST(rst_n), .Din(din), .Ld(ld),
    .Busy(p_busy), .Valid(p_valid), .Tens(p_tens), .Ones(p_ones),
    .Seg(p_seg), .Dsel(p_dsel)
  );

  sum_bcd_display_driver #(.SUM_W(SUM_W), .SCAN_DIV(SD), .SEG_POL(1'b0)) dut_n (
    .CLK(clk), .RST(rst_n), .Din(din), .Ld(ld),
    .Busy(n_busy), .Valid(n_valid), .Tens(n_tens), .Ones(n_ones),
    .Seg(n_seg), .Dsel(n_dsel)
  );

  typedef struct {
    int tens;
    int ones;
    int due;
  } exp_t;

  exp_t q[$];
  exp_t ent;
  exp_t got;

  int errors    = 0;
  int checks    = 0;
  int edge_n    = 0;
  int free_edge = 0;
  int busy_last = -1;
  int since_rst = 0;
  int disp_t    = 0;
  int disp_o    = 0;
  bit started   = 1'b0;

  logic [6:0] seg_ref [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                               7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  // Reference model: accepted loads become expected results due SUM_W+1 edges
  // later; the scanner position follows from whole SD-cycle slots since reset.
  always @(posedge clk) begin
    logic [6:0] es;
    logic [6:0] esn;
    int         tens_slot;
    edge_n++;
    if (!rst_n) begin
      started   = 1'b1;
      q.delete();
      disp_t    = 0;
      disp_o    = 0;
      free_edge = 0;
      busy_last = -1;
      since_rst = 0;
    end else if (started) begin
      since_rst++;
      if (ld && edge_n >= free_edge) begin
        ent.tens  = int'(din) / 10;
        ent.ones  = int'(din) % 10;
        ent.due   = edge_n + SUM_W + 1;
        q.push_back(ent);
        free_edge = edge_n + SUM_W + 2;
        busy_last = edge_n + SUM_W;
      end
    end
    if (q.size() > 0 && q[0].due == edge_n) begin
      disp_t = q[0].tens;
      disp_o = q[0].ones;
    end
    #2;
    if (started) begin
      if (p_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got Valid=1 tens=%0d ones=%0d, expected Valid=0 (edge %0d)",
                   p_tens, p_ones, edge_n);
        end else begin
          got = q.pop_front();
          $display("txn edge %0d: tens=%0d ones=%0d (expected %0d/%0d due edge %0d)",
                   edge_n, p_tens, p_ones, got.tens, got.ones, got.due);
          check("valid_tens", int'(p_tens), got.tens);
          check("valid_ones", int'(p_ones), got.ones);
          check("valid_latency", edge_n, got.due);
        end
      end else if (q.size() > 0 && q[0].due <= edge_n) begin
        got = q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid: got Valid=0, expected Valid=1 with %0d/%0d (edge %0d)",
                 got.tens, got.ones, edge_n);
      end
      tens_slot = (since_rst / SD) % 2;
      if (tens_slot == 1) es = (disp_t == 0) ? 7'h00 : seg_ref[disp_t];
      else                es = seg_ref[disp_o];
      esn = ~es;
      check("busy",     int'(p_busy), (edge_n <= busy_last) ? 1 : 0);
      check("dsel",     int'(p_dsel), (tens_slot == 1) ? 2 : 1);
      check("tens",     int'(p_tens), disp_t);
      check("ones",     int'(p_ones), disp_o);
      check("seg",      int'(p_seg), int'(es));
      check("seg_n",    int'(n_seg), int'(esn));
      check("valid_n",  int'(n_valid), int'(p_valid));
      check("busy_n",   int'(n_busy), int'(p_busy));
      check("digits_n", int'({n_tens, n_ones}), int'({p_tens, p_ones}));
      check("dsel_n",   int'(n_dsel), int'(p_dsel));
    end
  end

  task automatic pulse(input int d);
    din = SUM_W'(d);
    ld  = 1'b1;
    @(negedge clk);
    ld  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int r;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(3 * SD);
    pulse(18);
    idle(10);
    // back-to-back: second Ld lands in the IDLE cycle right after DONE
    pulse(31);
    idle(6);
    pulse(0);
    idle(10);
    // Ld during SHIFT is ignored
    pulse(25);
    idle(2);
    pulse(9);
    idle(10);
    // reset mid-conversion, then a normal conversion
    pulse(20);
    idle(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse(13);
    idle(10);
    pulse(7);
    idle(2 * SD);
    for (int i = 0; i < 400; i++) begin
      r     = int'($urandom_range(0, 99));
      din   = SUM_W'($urandom_range(0, (1 << SUM_W) - 1));
      ld    = (r < 30);
      rst_n = (r != 99);
      @(negedge clk);
    end
    ld    = 1'b0;
    rst_n = 1'b1;
    idle(12);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
